// File: rtl/psg_envelope_generator.sv
// AY-3-8913-compatible envelope generator: period counter, 16-step ramp and
// CONT/ATT/ALT/HOLD shape sequencing, producing the 4-bit envelope amplitude.
module psg_envelope_generator #(
  parameter int unsigned PERIOD_BITS = 16,
  parameter int unsigned STEP_BITS   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   restart,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [3:0]             shape,
  output logic [STEP_BITS-1:0]   envelope,
  output logic                   holding,
  output logic                   step_pulse
);

  localparam int unsigned Cont = 3;
  localparam int unsigned Att  = 2;
  localparam int unsigned Alt  = 1;
  localparam int unsigned Hold = 0;

  localparam logic [PERIOD_BITS-1:0] PeriodOne = PERIOD_BITS'(1);
  localparam logic [STEP_BITS-1:0]   StepOne   = STEP_BITS'(1);
  localparam logic [STEP_BITS-1:0]   StepMax   = '1;

  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [STEP_BITS-1:0]   step_q, step_d;
  logic [3:0]             shape_q, shape_d;
  logic                   flip_q, flip_d;
  logic                   hold_q, hold_d;
  logic [STEP_BITS-1:0]   hold_val_q, hold_val_d;

  logic [PERIOD_BITS-1:0] period_last;
  logic                   dir;
  logic                   advance;

  // Period 0 behaves as period 1, so the last count index is 0 for both.
  assign period_last = (period == '0) ? '0 : period - PeriodOne;
  assign dir         = shape_q[Att] ^ flip_q;
  // >= rather than == so a period shortened below cnt advances on the next tick.
  assign advance     = tick && !hold_q && (cnt_q >= period_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      step_q     <= '0;
      shape_q    <= '0;
      flip_q     <= 1'b0;
      hold_q     <= 1'b1;
      hold_val_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      shape_q    <= shape_d;
      flip_q     <= flip_d;
      hold_q     <= hold_d;
      hold_val_q <= hold_val_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    step_d     = step_q;
    shape_d    = shape_q;
    flip_d     = flip_q;
    hold_d     = hold_q;
    hold_val_d = hold_val_q;
    if (restart) begin
      cnt_d   = '0;
      step_d  = '0;
      flip_d  = 1'b0;
      hold_d  = 1'b0;
      shape_d = shape;
    end else if (tick && !hold_q) begin
      if (advance) begin
        cnt_d = '0;
        if (step_q != StepMax) begin
          step_d = step_q + StepOne;
        end else if (!shape_q[Cont]) begin
          hold_d     = 1'b1;
          hold_val_d = '0;
        end else if (shape_q[Hold]) begin
          // ALT inverts the final value of the ramp that just completed.
          hold_d     = 1'b1;
          hold_val_d = (dir ^ shape_q[Alt]) ? StepMax : '0;
        end else begin
          step_d = '0;
          if (shape_q[Alt]) begin
            flip_d = ~flip_q;
          end
        end
      end else begin
        cnt_d = cnt_q + PeriodOne;
      end
    end
  end

  always_comb begin
    holding    = hold_q;
    step_pulse = advance && !restart && !reset;
    if (hold_q) begin
      envelope = hold_val_q;
    end else if (dir) begin
      envelope = step_q;
    end else begin
      envelope = ~step_q;
    end
  end

endmodule
